// File: rtl/user_cnn_mac.sv
// OBI subordinate for the user-domain CNN accelerator: 3x3 signed-weight by
// unsigned-pixel MAC with bias, optional ReLU, sticky DONE and result register.

package croc_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } sbr_obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } sbr_obi_rsp_t;
endpackage

module user_cnn_mac #(
    parameter croc_pkg::obi_cfg_t ObiCfg    = croc_pkg::SbrObiCfg,
    parameter type                obi_req_t = croc_pkg::sbr_obi_req_t,
    parameter type                obi_rsp_t = croc_pkg::sbr_obi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     done_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MAC    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]  state;
    logic [3:0]  idx;
    logic [31:0] acc;
    logic [31:0] result;
    logic [31:0] bias;
    logic [7:0]  weight [9];
    logic [7:0]  pixel  [9];
    logic        relu_en;
    logic        done;

    logic                      rvalid_q;
    logic                      err_q;
    logic [31:0]               rdata_q;
    logic [ObiCfg.IdWidth-1:0] rid_q;

    logic [9:0]  word;
    logic [3:0]  sel;
    logic        is_ctrl, is_status, is_result, is_bias, is_w, is_p, mapped;
    logic        busy, acc_err, wr_ok;
    logic [31:0] rd_data;
    logic [16:0] w_ext, p_ext, prod;
    logic        unused_addr_bits;

    assign word = obi_req_i.addr[11:2];
    assign sel  = word[3:0];
    assign busy = (state != IDLE);
    assign unused_addr_bits = ^{obi_req_i.addr[31:12], obi_req_i.addr[1:0]};

    always_comb begin
        is_ctrl   = (word == 10'd0);
        is_status = (word == 10'd1);
        is_result = (word == 10'd2);
        is_bias   = (word == 10'd3);
        is_w      = (word >= 10'd16) && (word <= 10'd24);
        is_p      = (word >= 10'd32) && (word <= 10'd40);
        mapped    = is_ctrl | is_status | is_result | is_bias | is_w | is_p;
        acc_err   = !mapped
                  || (obi_req_i.we && (is_result || ((is_bias || is_w || is_p) && busy)));
        wr_ok     = obi_req_i.req && obi_req_i.we && !acc_err;
    end

    always_comb begin
        rd_data = '0;
        if (is_ctrl)   rd_data[1]   = relu_en;
        if (is_status) rd_data[1:0] = {done, busy};
        if (is_result) rd_data      = result;
        if (is_bias)   rd_data      = bias;
        if (is_w)      rd_data[7:0] = weight[sel];
        if (is_p)      rd_data[7:0] = pixel[sel];
    end

    // 17-bit modular multiply of sign/zero-extended operands yields the exact signed product.
    assign w_ext = {{9{weight[idx][7]}}, weight[idx]};
    assign p_ext = {9'b0, pixel[idx]};
    assign prod  = w_ext * p_ext;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            result   <= '0;
            bias     <= '0;
            relu_en  <= 1'b0;
            done     <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            for (int unsigned i = 0; i < 9; i++) begin
                weight[i] <= '0;
                pixel[i]  <= '0;
            end
        end else begin
            rvalid_q <= obi_req_i.req;
            rid_q    <= obi_req_i.aid;
            err_q    <= obi_req_i.req && acc_err;
            rdata_q  <= (obi_req_i.req && !obi_req_i.we && !acc_err) ? rd_data : '0;

            if (wr_ok && is_bias) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (obi_req_i.be[b]) bias[8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
                end
            end
            if (wr_ok && is_w && obi_req_i.be[0]) weight[sel] <= obi_req_i.wdata[7:0];
            if (wr_ok && is_p && obi_req_i.be[0]) pixel[sel]  <= obi_req_i.wdata[7:0];
            if (wr_ok && is_status && obi_req_i.wdata[1]) done <= 1'b0;

            // FSM assignments follow the W1C so a same-cycle DONE set takes priority.
            case (state)
                IDLE: begin
                    if (wr_ok && is_ctrl) begin
                        relu_en <= obi_req_i.wdata[1];
                        if (obi_req_i.wdata[0]) begin
                            acc   <= bias;
                            idx   <= '0;
                            done  <= 1'b0;
                            state <= MAC;
                        end
                    end
                end
                MAC: begin
                    acc <= acc + {{15{prod[16]}}, prod};
                    if (idx == 4'd8) state <= FINISH;
                    else             idx   <= idx + 4'd1;
                end
                FINISH: begin
                    result <= (relu_en && acc[31]) ? '0 : acc;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = obi_req_i.req;
        obi_rsp_o.rvalid = rvalid_q;
        obi_rsp_o.rdata  = rdata_q;
        obi_rsp_o.rid    = rid_q;
        obi_rsp_o.err    = err_q;
    end

    assign done_o = done;

endmodule

// File: tb/tb_user_cnn_mac.sv
// Randomized self-checking bench for user_cnn_mac against an arithmetic
// reference model of the kernel, pixel window and bias.

module tb_user_cnn_mac;

    logic                   clk;
    logic                   rst;
    croc_pkg::sbr_obi_req_t req;
    croc_pkg::sbr_obi_rsp_t rsp;
    logic                   done;

    int n_total = 0;
    int n_pass  = 0;

    byte          mw [9];
    byte unsigned mp [9];
    int           mbias;
    logic [31:0]  last_result;

    user_cnn_mac #(
        .ObiCfg    (croc_pkg::SbrObiCfg),
        .obi_req_t (croc_pkg::sbr_obi_req_t),
        .obi_rsp_t (croc_pkg::sbr_obi_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .done_o    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_result(input bit relu);
        int s;
        s = mbias;
        for (int i = 0; i < 9; i++) s = s + int'(mw[i]) * int'(mp[i]);
        return (relu && s < 0) ? 32'd0 : 32'(s);
    endfunction

    // One OBI transaction; starts just after a rising edge, returns just after the response edge.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        logic aid;
        aid       = 1'($urandom);
        req.req   = 1'b1;
        req.we    = we;
        req.addr  = addr;
        req.be    = be;
        req.wdata = wdata;
        req.aid   = aid;
        #1;
        check("gnt", 32'(rsp.gnt), 32'd1);
        @(posedge clk);
        #1;
        check("rvalid", 32'(rsp.rvalid), 32'd1);
        check("rid", 32'(rsp.rid), 32'(aid));
        rdata   = rsp.rdata;
        err     = rsp.err;
        req.req = 1'b0;
        req.we  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic exp_err);
        logic [31:0] rd;
        logic        e;
        bus(1'b1, addr, be, data, rd, e);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                          input logic exp_err);
        logic [31:0] rd;
        logic        e;
        bus(1'b0, addr, 4'hF, 32'h0, rd, e);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        check(tag, rd, exp);
    endtask

    task automatic load_all();
        for (int i = 0; i < 9; i++) begin
            wr("w_wr", 32'h2000_1040 + 32'(4 * i), {24'h0, 8'(mw[i])}, 4'hF, 1'b0);
            wr("p_wr", 32'h2000_1080 + 32'(4 * i), {24'h0, mp[i]}, 4'hF, 1'b0);
        end
        wr("bias_wr", 32'h2000_100C, 32'(mbias), 4'hF, 1'b0);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk);
            #1;
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] ctrl);
        wr({tag, "_start"}, 32'h2000_1000, ctrl, 4'hF, 1'b0);
        wait_done();
        last_result = model_result(ctrl[1]);
        rd_chk({tag, "_result"}, 32'h2000_1008, last_result, 1'b0);
        rd_chk({tag, "_status"}, 32'h2000_1004, 32'h2, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mw[i] = 0;
            mp[i] = 0;
        end
        mbias = 0;
        last_result = '0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        req = '0;
        do_reset();

        // Reset state
        check("rst_rvalid", 32'(rsp.rvalid), 32'd0);
        check("rst_gnt", 32'(rsp.gnt), 32'd0);
        check("rst_done_o", 32'(done), 32'd0);
        for (int a = 0; a < 4; a++) rd_chk("rst_reg", 32'h2000_1000 + 32'(4 * a), 32'h0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            rd_chk("rst_w", 32'h2000_1040 + 32'(4 * i), 32'h0, 1'b0);
            rd_chk("rst_p", 32'h2000_1080 + 32'(4 * i), 32'h0, 1'b0);
        end
        rd_chk("unmapped_20", 32'h2000_1020, 32'h0, 1'b1);
        rd_chk("unmapped_64", 32'h2000_1064, 32'h0, 1'b1);
        rd_chk("unmapped_a4", 32'h2000_10A4, 32'h0, 1'b1);

        // Ones kernel over 1..9: exact completion timing
        for (int i = 0; i < 9; i++) begin
            mw[i] = 1;
            mp[i] = byte'(i + 1);
        end
        mbias = 0;
        load_all();
        wr("t1_start", 32'h2000_1000, 32'h1, 4'hF, 1'b0);
        for (int k = 0; k < 10; k++) begin
            check("t1_busy_done_low", 32'(done), 32'd0);
            @(posedge clk);
            #1;
        end
        check("t1_done_o", 32'(done), 32'd1);
        rd_chk("t1_status", 32'h2000_1004, 32'h2, 1'b0);
        rd_chk("t1_result", 32'h2000_1008, 32'd45, 1'b0);
        wr("t1_w1c", 32'h2000_1004, 32'h2, 4'hF, 1'b0);
        rd_chk("t1_status_clr", 32'h2000_1004, 32'h0, 1'b0);
        check("t1_done_o_clr", 32'(done), 32'd0);

        // All -1 by 255 with bias 100, without and with ReLU
        for (int i = 0; i < 9; i++) begin
            mw[i] = -1;
            mp[i] = 8'd255;
        end
        mbias = 100;
        load_all();
        run_and_check("t2", 32'h1);
        check("t2_value", last_result, 32'hFFFF_F76D);
        run_and_check("t2r", 32'h3);
        check("t2r_value", last_result, 32'h0);
        rd_chk("t2r_ctrl", 32'h2000_1000, 32'h2, 1'b0);

        // Accesses while busy
        run_and_check("t3a", 32'h1);
        wr("t3_start", 32'h2000_1000, 32'h1, 4'hF, 1'b0);
        wr("t3_pix_busy", 32'h2000_1080, 32'h12, 4'hF, 1'b1);
        wr("t3_start_busy", 32'h2000_1000, 32'h3, 4'hF, 1'b0);
        wr("t3_result_wr", 32'h2000_1008, 32'h5, 4'hF, 1'b1);
        rd_chk("t3_result_busy", 32'h2000_1008, last_result, 1'b0);
        rd_chk("t3_status_busy", 32'h2000_1004, 32'h1, 1'b0);
        wait_done();
        rd_chk("t3_result", 32'h2000_1008, model_result(1'b0), 1'b0);
        rd_chk("t3_pix_kept", 32'h2000_1080, 32'hFF, 1'b0);
        rd_chk("t3_ctrl_kept", 32'h2000_1000, 32'h0, 1'b0);

        // Wrap-around and byte-enabled bias write
        for (int i = 0; i < 9; i++) begin
            mw[i] = 0;
            mp[i] = 0;
        end
        mw[0] = 127;
        mp[0] = 8'd255;
        mbias = 32'h7FFF_FFFF;
        load_all();
        run_and_check("t4", 32'h1);
        check("t4_value", last_result, 32'h8000_7E80);
        wr("t4_bias_be", 32'h2000_100C, 32'hAABB_CCDD, 4'b0010, 1'b0);
        rd_chk("t4_bias", 32'h2000_100C, 32'h7FFF_CCFF, 1'b0);
        mbias = 32'h7FFF_CCFF;
        wr("t4_w_nobe", 32'h2000_1040, 32'h0000_0055, 4'b1110, 1'b0);
        rd_chk("t4_w_kept", 32'h2000_1040, 32'h7F, 1'b0);

        // Randomized kernels
        for (int n = 0; n < 6; n++) begin
            logic [31:0] c;
            for (int i = 0; i < 9; i++) begin
                mw[i] = byte'($urandom);
                mp[i] = byte'($urandom);
            end
            mbias = int'($urandom_range(0, 4000)) - 2000;
            load_all();
            c = {30'h0, 1'($urandom), 1'b1};
            run_and_check("rand", c);
        end

        // Reset during MAC idx=4
        wr("t5_start", 32'h2000_1000, 32'h1, 4'hF, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mw[i] = 0;
            mp[i] = 0;
        end
        mbias = 0;
        check("t5_done_o", 32'(done), 32'd0);
        rd_chk("t5_status", 32'h2000_1004, 32'h0, 1'b0);
        rd_chk("t5_result", 32'h2000_1008, 32'h0, 1'b0);
        rd_chk("t5_bias", 32'h2000_100C, 32'h0, 1'b0);
        mw[2] = -7;
        mp[2] = 8'd200;
        mw[5] = 3;
        mp[5] = 8'd11;
        mbias = 5;
        load_all();
        run_and_check("t5_fresh", 32'h1);

        // Back-to-back reads (rid checked inside each transaction)
        for (int i = 0; i < 6; i++) rd_chk("b2b", 32'h2000_1080 + 32'(4 * i), {24'h0, mp[i]}, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
